projectile_engine: RTL and testbench
====================================

Name: projectile_engine

Overview:
Per-frame projectile manager for the tank game. Holds PLAYERS×SLOTS projectiles, spawns them on fire requests, and advances each one once per frame. It checks every projectile against the shared tile map through a one-cycle-latency read port, and destroys breakable walls through a write port. It sits between the tank controllers, the tile-map memory and color_mapper, and is clocked by the 50 MHz system clock with frame timing taken from VGA vsync.

Parameters:
PLAYERS, 2, number of players / projectile owners
SLOTS, 4, projectile slots per player
MAP_COLS, 20, map width in tiles
MAP_ROWS, 15, map height in tiles
TILE_SHIFT, 5, log2 of tile edge in pixels (32)
SPEED, 4, pixels moved per frame
COORD_W, 10, pixel coordinate width
ADDR_W (localparam), clog2(MAP_COLS*MAP_ROWS), map address width

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  VGA vsync level; asynchronous to the engine
fire  in  PLAYERS  one-cycle fire request per player
fire_x  in  PLAYERS*COORD_W  spawn X per player
fire_y  in  PLAYERS*COORD_W  spawn Y per player
fire_dir  in  PLAYERS*2  direction: 0 up, 1 right, 2 down, 3 left
map_rd_addr  out  ADDR_W  tile index = row*MAP_COLS+col
map_rd_data  in  3  tile code, valid one cycle after the address
map_wr_en  out  1  tile write strobe
map_wr_addr  out  ADDR_W  tile write index
map_wr_data  out  3  always 0 when written
proj_active  out  PLAYERS*SLOTS  slot valid; slot k belongs to player k/SLOTS
proj_x  out  PLAYERS*SLOTS*COORD_W  projectile X
proj_y  out  PLAYERS*SLOTS*COORD_W  projectile Y
base_hit  out  PLAYERS  sticky; bit p set when player p's base is hit
busy  out  1  high while the frame walk is in progress

Behaviour:
- Reset: all slots inactive, all positions 0, base_hit 0, map_wr_en 0, map addresses 0, busy 0, pending registers cleared, FSM in IDLE.
- Frame detection: frame_clk passes through a 2-flop synchroniser. A rising edge sets frame_pend.
- Fire capture: fire[p] sets fire_pend[p]. fire_x, fire_y and fire_dir are latched on the same cycle; a later fire overwrites the earlier one. A fire and a frame edge arriving in the same cycle are served in that frame.
- FSM:
  - IDLE: if frame_pend, clear it, set busy and go to SPAWN.
  - SPAWN, 1 cycle: for each player with fire_pend, activate that player's lowest-index inactive slot with the latched position and direction. If no slot is free, drop the request. Clear all fire_pend.
  - MOVE: for the current slot, if inactive, advance the slot index in 1 cycle. If active, step by SPEED in its direction:
    - Up with y<SPEED, or left with x<SPEED: deactivate, skip the slot.
    - New x ≥ MAP_COLS<<TILE_SHIFT or new y ≥ MAP_ROWS<<TILE_SHIFT: deactivate, skip the slot.
    - Otherwise store the new position and go to READ.
  - READ: drive map_rd_addr from the new position's tile, then WAIT, then CHECK.
  - CHECK: act on the tile code:
    - 0: keep the projectile.
    - 1: deactivate.
    - 2: deactivate; map_wr_en=1 for exactly one cycle with map_wr_addr = that tile and data 0.
    - 3: deactivate; set base_hit[0].
    - 4: deactivate; set base_hit[1].
    - 5–7: deactivate.
    - Then advance the slot index.
  - After the last slot, go to IDLE and clear busy.
- Per-slot cost: 1 cycle inactive, 4 cycles active. A full walk therefore takes at most 2+4·PLAYERS·SLOTS cycles.
- Frame overrun: a frame edge arriving while busy is held in frame_pend (one deep; further edges are merged) and served right after IDLE.
- Timing: outputs update only inside the walk. color_mapper samples them during active video.
- base_hit stays set until Reset.
- Reset asserted mid-walk returns everything to reset values immediately; no partial write is left asserted.

Optional Feature:
PROJ_HIT_COUNT_EN
- Defined: adds output hit_count (PLAYERS*8). Each tile-2 destruction by a slot of player p increments hit_count[p], saturating at 255. Reset clears it to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-walk: assert Reset during READ -> proj_active=0, map_wr_en=0, busy=0 within the same cycle.
- Travel: fire[0] with (100,100), dir 1, map all 0 -> after frame 1 slot 0 at (104,100); after frame 2 at (108,100); busy drops ≤34 cycles after each sync edge.
- Wall break: map tile (row 3, col 4)=2, fire (124,100) dir 1 -> next frame map_wr_en pulses once with addr 64 and data 0; slot 0 inactive; with PROJ_HIT_COUNT_EN, hit_count[0]=1.
- Base hit and walls: tile 13·20+9=269 is 3, projectile moving down into it -> base_hit[0]=1 and stays 1; tile code 1 -> deactivate, no write.
- Slot exhaustion: 5 fires from player 0 over 5 frames with no hits -> slots 0–3 active; 5th request dropped; player 1 slots unaffected.
- Boundaries and overrun: dir 0 at y=2 -> deactivated with no map read. Two sync edges during one walk -> exactly one extra walk follows.

Source files
------------

// File: rtl/projectile_engine.sv
// Per-frame projectile manager: spawns on fire, walks all slots once per vsync, checks the tile map.
// Optional PROJ_HIT_COUNT_EN adds per-player saturating wall-break counters on hit_count.
module projectile_engine #(
  parameter int PLAYERS    = 2,
  parameter int SLOTS      = 4,
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int TILE_SHIFT = 5,
  parameter int SPEED      = 4,
  parameter int COORD_W    = 10,
  localparam int ADDR_W    = $clog2(MAP_COLS*MAP_ROWS)
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic [PLAYERS-1:0]               fire,
  input  logic [PLAYERS*COORD_W-1:0]       fire_x,
  input  logic [PLAYERS*COORD_W-1:0]       fire_y,
  input  logic [PLAYERS*2-1:0]             fire_dir,
  output logic [ADDR_W-1:0]                map_rd_addr,
  input  logic [2:0]                       map_rd_data,
  output logic                             map_wr_en,
  output logic [ADDR_W-1:0]                map_wr_addr,
  output logic [2:0]                       map_wr_data,
  output logic [PLAYERS*SLOTS-1:0]         proj_active,
  output logic [PLAYERS*SLOTS*COORD_W-1:0] proj_x,
  output logic [PLAYERS*SLOTS*COORD_W-1:0] proj_y,
  output logic [PLAYERS-1:0]               base_hit,
`ifdef PROJ_HIT_COUNT_EN
  output logic [PLAYERS*8-1:0]             hit_count,
  output logic                             busy
`else
  output logic                             busy
`endif
);
  localparam int N    = PLAYERS*SLOTS;
  localparam int SW   = (N > 1) ? $clog2(N) : 1;
  localparam int XMAX = MAP_COLS << TILE_SHIFT;
  localparam int YMAX = MAP_ROWS << TILE_SHIFT;

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_MOVE, S_READ, S_WAIT, S_CHECK} state_t;
  state_t r_state, w_next;

  logic [2:0]                          r_fs;
  logic                                r_frame_pend;
  logic [PLAYERS-1:0]                  r_fire_pend;
  logic [PLAYERS-1:0][COORD_W-1:0]     r_fx, r_fy;
  logic [PLAYERS-1:0][1:0]             r_fdir;
  logic [N-1:0]                        r_act;
  logic [N-1:0][COORD_W-1:0]           r_x, r_y;
  logic [N-1:0][1:0]                   r_dir;
  logic [SW-1:0]                       r_slot;
  logic [ADDR_W-1:0]                   r_rd_addr, r_wr_addr;
  logic                                r_wr_en;
  logic [PLAYERS-1:0]                  r_base_hit;

  logic                                w_rise, w_cact, w_off, w_last, w_found;
  logic [COORD_W-1:0]                  w_cx, w_cy;
  logic [1:0]                          w_cd;
  logic [COORD_W:0]                    w_nx, w_ny;
  logic [ADDR_W-1:0]                   w_tile;
  logic [N-1:0]                        w_spawn;

  assign w_rise = r_fs[1] & ~r_fs[2];
  assign w_cact = r_act[r_slot];
  assign w_cx   = r_x[r_slot];
  assign w_cy   = r_y[r_slot];
  assign w_cd   = r_dir[r_slot];
  assign w_last = (r_slot == SW'(N-1));
  assign w_tile = ADDR_W'(w_cy >> TILE_SHIFT) * ADDR_W'(MAP_COLS) + ADDR_W'(w_cx >> TILE_SHIFT);

  always_comb begin
    w_nx = {1'b0, w_cx};
    w_ny = {1'b0, w_cy};
    case (w_cd)
      2'd0:    w_ny = w_ny - (COORD_W+1)'(SPEED);
      2'd1:    w_nx = w_nx + (COORD_W+1)'(SPEED);
      2'd2:    w_ny = w_ny + (COORD_W+1)'(SPEED);
      default: w_nx = w_nx - (COORD_W+1)'(SPEED);
    endcase
  end

  // Leaving the map on any side retires the slot without a map read.
  assign w_off = (w_cd == 2'd0 && w_cy < COORD_W'(SPEED)) ||
                 (w_cd == 2'd3 && w_cx < COORD_W'(SPEED)) ||
                 (w_nx >= (COORD_W+1)'(XMAX)) || (w_ny >= (COORD_W+1)'(YMAX));

  always_comb begin
    w_spawn = '0;
    w_found = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_found = 1'b0;
      for (int s = 0; s < SLOTS; s++)
        if (r_fire_pend[p] && !w_found && !r_act[p*SLOTS+s]) begin
          w_spawn[p*SLOTS+s] = 1'b1;
          w_found            = 1'b1;
        end
    end
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_frame_pend) w_next = S_SPAWN;
      S_SPAWN: w_next = S_MOVE;
      S_MOVE:  if (w_cact && !w_off) w_next = S_READ;
               else if (w_last)      w_next = S_IDLE;
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_CHECK;
      S_CHECK: w_next = w_last ? S_IDLE : S_MOVE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_fs <= '0; r_frame_pend <= 1'b0; r_fire_pend <= '0;
      r_fx <= '0; r_fy <= '0; r_fdir <= '0;
      r_act <= '0; r_x <= '0; r_y <= '0; r_dir <= '0; r_slot <= '0;
      r_rd_addr <= '0; r_wr_addr <= '0; r_wr_en <= 1'b0; r_base_hit <= '0;
    end else begin
      r_fs    <= {r_fs[1:0], frame_clk};
      r_wr_en <= 1'b0;
      // A new edge always wins over the clear so overrun edges are never lost.
      if (w_rise)                r_frame_pend <= 1'b1;
      else if (r_state == S_IDLE) r_frame_pend <= 1'b0;
      for (int p = 0; p < PLAYERS; p++)
        if (fire[p]) begin
          r_fire_pend[p] <= 1'b1;
          r_fx[p]        <= fire_x[p*COORD_W +: COORD_W];
          r_fy[p]        <= fire_y[p*COORD_W +: COORD_W];
          r_fdir[p]      <= fire_dir[p*2 +: 2];
        end else if (r_state == S_SPAWN) r_fire_pend[p] <= 1'b0;
      case (r_state)
        S_SPAWN:
          for (int k = 0; k < N; k++)
            if (w_spawn[k]) begin
              r_act[k] <= 1'b1;
              r_x[k]   <= r_fx[k/SLOTS];
              r_y[k]   <= r_fy[k/SLOTS];
              r_dir[k] <= r_fdir[k/SLOTS];
            end
        S_MOVE:
          if (w_cact && !w_off) begin
            r_x[r_slot] <= w_nx[COORD_W-1:0];
            r_y[r_slot] <= w_ny[COORD_W-1:0];
          end else begin
            r_act[r_slot] <= 1'b0;
            r_slot        <= w_last ? '0 : r_slot + 1'b1;
          end
        S_READ: r_rd_addr <= w_tile;
        S_CHECK: begin
          if (map_rd_data != 3'd0) r_act[r_slot] <= 1'b0;
          if (map_rd_data == 3'd2) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_rd_addr;
          end
          if (map_rd_data == 3'd3) r_base_hit[0] <= 1'b1;
          if (map_rd_data == 3'd4) r_base_hit[1] <= 1'b1;
          r_slot <= w_last ? '0 : r_slot + 1'b1;
        end
        default: ;
      endcase
    end

`ifdef PROJ_HIT_COUNT_EN
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  logic [PLAYERS-1:0][7:0] r_hits;
  logic [PW-1:0]           w_owner;
  assign w_owner = PW'(r_slot / SW'(SLOTS));

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_hits <= '0;
    else if (r_state == S_CHECK && map_rd_data == 3'd2 && r_hits[w_owner] != 8'hFF)
      r_hits[w_owner] <= r_hits[w_owner] + 8'd1;

  assign hit_count = r_hits;
`endif

  assign busy        = (r_state != S_IDLE);
  assign map_rd_addr = r_rd_addr;
  assign map_wr_en   = r_wr_en;
  assign map_wr_addr = r_wr_addr;
  assign map_wr_data = 3'd0;
  assign proj_active = r_act;
  assign proj_x      = r_x;
  assign proj_y      = r_y;
  assign base_hit    = r_base_hit;
endmodule

// File: tb/tb_projectile_engine.sv
// Directed bench for projectile_engine: tile map modelled as a 1-cycle read RAM, write strobes logged.
module tb_projectile_engine;
  localparam int CW = 10;
  localparam int NS = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_clk = 1'b0;
  logic [1:0]    fire = '0;
  logic [19:0]   fire_x = '0, fire_y = '0;
  logic [3:0]    fire_dir = '0;
  logic [8:0]    map_rd_addr, map_wr_addr;
  logic [2:0]    map_rd_data = '0, map_wr_data;
  logic          map_wr_en, busy;
  logic [7:0]    proj_active;
  logic [79:0]   proj_x, proj_y;
  logic [1:0]    base_hit;
`ifdef PROJ_HIT_COUNT_EN
  logic [15:0]   hit_count;
`endif

  projectile_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .fire(fire), .fire_x(fire_x), .fire_y(fire_y), .fire_dir(fire_dir),
    .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
    .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
    .proj_active(proj_active), .proj_x(proj_x), .proj_y(proj_y),
    .base_hit(base_hit),
`ifdef PROJ_HIT_COUNT_EN
    .hit_count(hit_count),
`endif
    .busy(busy)
  );

  always #10 Clk = ~Clk;

  logic [2:0] mem [300];
  int         wr_cnt = 0, walk_cnt = 0;
  logic [8:0] wr_addr_q = '0;
  logic [2:0] wr_data_q = '0;
  logic       busy_q = 1'b0;
  int         n_chk = 0, n_fail = 0;

  always @(posedge Clk) map_rd_data <= mem[map_rd_addr];

  always @(posedge Clk) begin
    busy_q <= busy;
    if (busy && !busy_q) walk_cnt <= walk_cnt + 1;
    if (map_wr_en === 1'b1) begin
      wr_cnt    <= wr_cnt + 1;
      wr_addr_q <= map_wr_addr;
      wr_data_q <= map_wr_data;
    end
  end

  function automatic logic [9:0] px(input int k); return proj_x[k*CW +: CW]; endfunction
  function automatic logic [9:0] py(input int k); return proj_y[k*CW +: CW]; endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; fire = '0;
    for (int i = 0; i < 300; i++) mem[i] = 3'd0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic fire_one(input int p, input int x, input int y, input int d);
    @(negedge Clk);
    fire[p] = 1'b1;
    fire_x[p*CW +: CW] = CW'(x);
    fire_y[p*CW +: CW] = CW'(y);
    fire_dir[p*2 +: 2] = 2'(d);
    @(negedge Clk);
    fire = '0;
  endtask

  task automatic do_frame();
    int n;
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge Clk); n++; end
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_start busy=%0b expected 1", busy); end
    frame_clk = 1'b0;
    n = 0;
    while (busy && n < 60) begin @(negedge Clk); n++; end
    n_chk++;
    if (busy !== 1'b0 || n > 34) begin
      n_fail++; $display("FAIL walk_len cycles=%0d busy=%0b expected <=34 and 0", n, busy);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (proj_active !== 8'h00) begin n_fail++; $display("FAIL rst_active got %h exp 00", proj_active); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_chk++; if (base_hit !== 2'b00) begin n_fail++; $display("FAIL rst_base got %b exp 00", base_hit); end
    n_chk++; if (map_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b exp 0", map_wr_en); end
    n_chk++; if (map_rd_addr !== 9'd0 || proj_x !== '0) begin
      n_fail++; $display("FAIL rst_addr_pos rd_addr=%0d x0=%0d exp 0", map_rd_addr, px(0));
    end
    do_reset();
  endtask

  task automatic test_reset_mid_walk();
    int n;
    do_reset();
    fire_one(0, 100, 100, 1);
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge Clk); n++; end
    @(negedge Clk);            // slot 0 MOVE
    @(negedge Clk);            // slot 0 READ
    n_chk++; if (proj_active !== 8'h01) begin n_fail++; $display("FAIL mid_pre_active got %h exp 01", proj_active); end
    Reset = 1'b1;
    #1;
    n_chk++; if (proj_active !== 8'h00 || busy !== 1'b0 || map_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset active=%h busy=%b wr_en=%b exp 00 0 0", proj_active, busy, map_wr_en);
    end
    frame_clk = 1'b0;
    do_reset();
  endtask

  task automatic test_travel();
    do_reset();
    fire_one(0, 100, 100, 1);
    do_frame();
    n_chk++; if (proj_active !== 8'h01 || px(0) !== 10'd104 || py(0) !== 10'd100) begin
      n_fail++; $display("FAIL travel_f1 active=%h pos=(%0d,%0d) exp 01 (104,100)", proj_active, px(0), py(0));
    end
    do_frame();
    n_chk++; if (proj_active !== 8'h01 || px(0) !== 10'd108 || py(0) !== 10'd100) begin
      n_fail++; $display("FAIL travel_f2 active=%h pos=(%0d,%0d) exp 01 (108,100)", proj_active, px(0), py(0));
    end
  endtask

  task automatic test_wall_break();
    int w0;
    do_reset();
    mem[64] = 3'd2;
    fire_one(0, 124, 100, 1);
    w0 = wr_cnt;
    do_frame();
    n_chk++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wall_pulses got %0d exp 1", wr_cnt - w0); end
    n_chk++; if (wr_addr_q !== 9'd64 || wr_data_q !== 3'd0) begin
      n_fail++; $display("FAIL wall_write addr=%0d data=%0d exp 64 0", wr_addr_q, wr_data_q);
    end
    n_chk++; if (proj_active !== 8'h00) begin n_fail++; $display("FAIL wall_active got %h exp 00", proj_active); end
`ifdef PROJ_HIT_COUNT_EN
    n_chk++; if (hit_count !== 16'h0001) begin n_fail++; $display("FAIL wall_hits got %h exp 0001", hit_count); end
`endif
  endtask

  task automatic test_base_and_walls();
    int w0;
    do_reset();
    mem[269] = 3'd3;
    fire_one(0, 300, 412, 2);
    do_frame();
    n_chk++; if (base_hit !== 2'b01 || proj_active !== 8'h00) begin
      n_fail++; $display("FAIL base0 base_hit=%b active=%h exp 01 00", base_hit, proj_active);
    end
    do_frame();
    n_chk++; if (base_hit !== 2'b01) begin n_fail++; $display("FAIL base0_sticky got %b exp 01", base_hit); end
    mem[61] = 3'd1;
    w0 = wr_cnt;
    fire_one(1, 50, 100, 0);
    do_frame();
    n_chk++; if (proj_active !== 8'h00 || wr_cnt !== w0) begin
      n_fail++; $display("FAIL solid_wall active=%h writes=%0d exp 00 0", proj_active, wr_cnt - w0);
    end
    mem[62] = 3'd4;
    fire_one(1, 70, 100, 0);
    do_frame();
    n_chk++; if (base_hit !== 2'b11 || proj_active !== 8'h00) begin
      n_fail++; $display("FAIL base1 base_hit=%b active=%h exp 11 00", base_hit, proj_active);
    end
  endtask

  task automatic test_slot_exhaustion();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fire_one(0, 10, 10 + 20*i, 1);
      if (i == 4) fire_one(1, 10, 200, 1);
      do_frame();
    end
    n_chk++; if (proj_active !== 8'h1F) begin n_fail++; $display("FAIL exhaust_active got %h exp 1f", proj_active); end
    n_chk++; if (px(0) !== 10'd30 || py(0) !== 10'd10) begin
      n_fail++; $display("FAIL exhaust_slot0 pos=(%0d,%0d) exp (30,10)", px(0), py(0));
    end
    n_chk++; if (px(3) !== 10'd18 || py(3) !== 10'd70) begin
      n_fail++; $display("FAIL exhaust_slot3 pos=(%0d,%0d) exp (18,70)", px(3), py(3));
    end
    n_chk++; if (px(4) !== 10'd14 || py(4) !== 10'd200) begin
      n_fail++; $display("FAIL exhaust_p1 pos=(%0d,%0d) exp (14,200)", px(4), py(4));
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    fire_one(0, 100, 2, 0);
    fire_one(1, 638, 10, 1);
    do_frame();
    n_chk++; if (proj_active !== 8'h00) begin n_fail++; $display("FAIL bound_active got %h exp 00", proj_active); end
    n_chk++; if (map_rd_addr !== 9'd0) begin n_fail++; $display("FAIL bound_no_read rd_addr=%0d exp 0", map_rd_addr); end
  endtask

  task automatic test_overrun();
    int w0, n;
    do_reset();
    fire_one(0, 100, 100, 1);
    w0 = walk_cnt;
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge Clk); n++; end
    for (int i = 0; i < 4; i++) begin @(negedge Clk); frame_clk = ~frame_clk; end
    @(negedge Clk); frame_clk = 1'b0;
    n = 0;
    while (busy && n < 60) begin @(negedge Clk); n++; end
    n = 0;
    while (!busy && n < 20) begin @(negedge Clk); n++; end
    n = 0;
    while (busy && n < 60) begin @(negedge Clk); n++; end
    repeat (60) @(negedge Clk);
    n_chk++; if (walk_cnt - w0 !== 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL overrun_walks got %0d busy=%b exp 2 0", walk_cnt - w0, busy);
    end
    n_chk++; if (px(0) !== 10'd108) begin n_fail++; $display("FAIL overrun_pos x=%0d exp 108", px(0)); end
  endtask

  initial begin
    for (int i = 0; i < 300; i++) mem[i] = 3'd0;
    repeat (2) @(negedge Clk);
    test_reset();
    test_reset_mid_walk();
    test_travel();
    test_wall_break();
    test_base_and_walls();
    test_slot_exhaustion();
    test_boundaries();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
